triangle_assembler: RTL
=======================

TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - P_SCREEN_W, 320, screen width in pixels
  - P_SCREEN_H, 240, screen height in pixels
  - P_CULL_BACK, 1, 1 = cull triangles with area <= 0
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - i_clk  in  1  single clock; all logic on rising edge
  - i_rst_n  in  1  reset, asynchronous, active-low
  - i_vtx_valid  in  1  vertex from geometry_engine is valid
  - o_vtx_ready  out  1  block accepts a vertex
  - i_vtx_x  in  32  screen X, signed Q16.16
  - i_vtx_y  in  32  screen Y, signed Q16.16
  - i_vtx_z  in  8  depth, unsigned integer
  - o_tri_valid  out  1  triangle available to the rasterizer
  - i_tri_ready  in  1  rasterizer accepts the triangle
  - o_v0_x, o_v0_y, o_v1_x, o_v1_y, o_v2_x, o_v2_y  out  12 each  signed integer pixel coordinates
  - o_v0_z, o_v1_z, o_v2_z  out  8 each  depths
  - o_bb_xmin, o_bb_xmax  out  10  bounding box X, clamped to [0, P_SCREEN_W-1]
  - o_bb_ymin, o_bb_ymax  out  10  bounding box Y, clamped to [0, P_SCREEN_H-1]
  - o_area  out  25  signed doubled triangle area
  - o_tri_count  out  16  triangles emitted, wraps
  - o_cull_count  out  16  triangles culled, wraps

Function
REQ-003 A vertex SHALL be accepted on a cycle where i_vtx_valid && o_vtx_ready.
REQ-004 Fixed-point conversion SHALL floor the value (arithmetic bits [31:16]) and saturate it to the 12-bit range [-2048, 2047].
REQ-005 The FSM SHALL have the states S_COLLECT, S_SETUP, S_CULL and S_OUTPUT.
REQ-006 In S_COLLECT, o_vtx_ready SHALL be 1 and a 2-bit counter SHALL store each accepted vertex into slot 0, 1 or 2 in order; acceptance of slot 2 SHALL move the FSM to S_SETUP.
REQ-007 In S_SETUP (1 cycle), the block SHALL compute area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) using 13-bit differences, 26-bit products and a result truncated to 25 bits; it SHALL also compute the unclamped minimum and maximum of X and Y.
REQ-008 In S_CULL (1 cycle), the triangle SHALL be culled if (P_CULL_BACK && area <= 0), or xmax < 0, or ymax < 0, or xmin > P_SCREEN_W-1, or ymin > P_SCREEN_H-1.
REQ-009 A culled triangle SHALL increment o_cull_count and return the FSM to S_COLLECT; otherwise the block SHALL clamp the bounding box, register all outputs and enter S_OUTPUT.
REQ-010 In S_OUTPUT, o_tri_valid SHALL be 1 and all triangle outputs SHALL be held stable until i_tri_ready=1; the handshake SHALL increment o_tri_count and return the FSM to S_COLLECT.
REQ-011 o_vtx_ready SHALL be 0 in S_SETUP, S_CULL and S_OUTPUT, with no vertex buffering beyond the 3 slots.
REQ-012 Latency SHALL be: slot-2 acceptance at cycle N gives o_tri_valid=1 at cycle N+3, and the next vertex is accepted no earlier than the cycle after the output handshake.
REQ-013 A culled triangle SHALL allow the next vertex at cycle N+3.
REQ-014 Counters SHALL wrap from 0xFFFF to 0.

Reset
REQ-015 While i_rst_n=0, the block SHALL asynchronously force: state S_COLLECT, vertex counter 0, o_vtx_ready 0, o_tri_valid 0, and every data output and counter 0.
REQ-016 o_vtx_ready SHALL rise on the first clock edge after reset deassertion.
REQ-017 Reset mid-collection or mid-output SHALL discard any partial triangle without incrementing either counter.

Structure
REQ-018 Package render_pkg SHALL hold the screen constants, the coordinate widths (12/10/25) and the tri_state_t enum.
REQ-019 The sub-module edge_area SHALL compute the registered signed area (REQ-007) and be instantiated once.

Verification
REQ-020 Input (10,10,z5),(50,10,z6),(10,40,z7) in Q16.16 -> area=1200 and bbox x 10..50, y 10..40; o_tri_valid=1 three cycles after the third vertex; o_tri_count=1.
REQ-021 Input (10,10),(10,40),(50,10) -> area=-1200, culled, no o_tri_valid, o_cull_count=1; with P_CULL_BACK=0 the triangle is emitted instead.
REQ-022 Input (-100,-100),(-50,-100),(-100,-50) -> area=2500, culled as offscreen; input (-20,5),(400,5),(-20,300) -> bbox clamped to x 0..319, y 5..239.
REQ-023 Hold i_tri_ready=0 for 5 cycles while i_vtx_valid=1 -> outputs stable, o_vtx_ready=0, no vertex consumed; i_tri_ready=1 -> one handshake, then collection resumes.
REQ-024 Send 2 vertices, pulse i_rst_n low mid-cycle, then send 3 new vertices -> the first 2 are discarded and a triangle forms from the new 3; collinear input (0,0),(10,10),(20,20) -> area 0, culled.

Source files
------------

// File: rtl/render_pkg.sv
// render_pkg: shared constants and types for the triangle setup path.
//   SCREEN_W/SCREEN_H : default screen dimensions in pixels
//   COORD_W           : signed integer pixel coordinate width
//   BBOX_W            : clamped bounding-box coordinate width
//   AREA_W            : signed doubled-area width
//   tri_state_t       : triangle assembler FSM states
//   q16_to_pix()      : Q16.16 -> saturated 12-bit pixel coordinate
package render_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COORD_W  = 12;
  localparam int BBOX_W   = 10;
  localparam int AREA_W   = 25;
  localparam int DIFF_W   = COORD_W + 1;
  localparam int PROD_W   = 2 * DIFF_W;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SETUP   = 2'd1,
    S_CULL    = 2'd2,
    S_OUTPUT  = 2'd3
  } tri_state_t;

  // Taking the integer half of a two's-complement Q16.16 value is a floor,
  // not a truncation toward zero; the result is then saturated to 12 bits.
  function automatic logic signed [COORD_W-1:0] q16_to_pix(input logic signed [31:0] q);
    logic signed [15:0] ip;
    ip = q[31:16];
    if (ip > 16'sd2047)
      return 12'sd2047;
    else if (ip < -16'sd2048)
      return 12'sh800;
    else
      return ip[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/triangle_assembler_edge_area.sv
// edge_area: registered signed doubled triangle area.
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : capture a new area on this cycle
//   x0..y2            : signed 12-bit vertex coordinates
//   area              : (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), low 25 bits
module edge_area
  import render_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  input  logic signed [COORD_W-1:0] x2,
  input  logic signed [COORD_W-1:0] y2,
  output logic signed [AREA_W-1:0]  area
);

  logic signed [DIFF_W-1:0] dx1, dy1, dx2, dy2;
  logic signed [PROD_W-1:0] prod_a, prod_b;

  always_comb begin
    // One extra bit keeps any difference of two 12-bit values exact.
    dx1    = $signed({x1[COORD_W-1], x1}) - $signed({x0[COORD_W-1], x0});
    dy1    = $signed({y1[COORD_W-1], y1}) - $signed({y0[COORD_W-1], y0});
    dx2    = $signed({x2[COORD_W-1], x2}) - $signed({x0[COORD_W-1], x0});
    dy2    = $signed({y2[COORD_W-1], y2}) - $signed({y0[COORD_W-1], y0});
    prod_a = dx1 * dy2;
    prod_b = dx2 * dy1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      area <= '0;
    else if (en)
      area <= AREA_W'(prod_a - prod_b);
  end

endmodule

// File: rtl/triangle_assembler.sv
// triangle_assembler: groups three vertices into a triangle, computes its
// area and bounding box, culls back-facing / offscreen triangles and hands
// the rest to the rasterizer over a valid/ready handshake.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_vtx_valid/o_vtx_ready   : vertex handshake, i_vtx_x/y Q16.16, i_vtx_z depth
//   o_tri_valid/i_tri_ready   : triangle handshake
//   o_vN_x/y/z                : pixel coordinates and depths of vertex N
//   o_bb_*                    : bounding box clamped to the screen
//   o_area                    : signed doubled area
//   o_tri_count/o_cull_count  : wrapping emitted / culled triangle counters
module triangle_assembler
  import render_pkg::*;
#(
  parameter int P_SCREEN_W  = SCREEN_W,
  parameter int P_SCREEN_H  = SCREEN_H,
  parameter int P_CULL_BACK = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_vtx_valid,
  output logic                o_vtx_ready,
  input  logic [31:0]         i_vtx_x,
  input  logic [31:0]         i_vtx_y,
  input  logic [7:0]          i_vtx_z,
  output logic                o_tri_valid,
  input  logic                i_tri_ready,
  output logic [COORD_W-1:0]  o_v0_x,
  output logic [COORD_W-1:0]  o_v0_y,
  output logic [COORD_W-1:0]  o_v1_x,
  output logic [COORD_W-1:0]  o_v1_y,
  output logic [COORD_W-1:0]  o_v2_x,
  output logic [COORD_W-1:0]  o_v2_y,
  output logic [7:0]          o_v0_z,
  output logic [7:0]          o_v1_z,
  output logic [7:0]          o_v2_z,
  output logic [BBOX_W-1:0]   o_bb_xmin,
  output logic [BBOX_W-1:0]   o_bb_xmax,
  output logic [BBOX_W-1:0]   o_bb_ymin,
  output logic [BBOX_W-1:0]   o_bb_ymax,
  output logic [AREA_W-1:0]   o_area,
  output logic [15:0]         o_tri_count,
  output logic [15:0]         o_cull_count
);

  localparam logic signed [COORD_W-1:0] X_LAST = COORD_W'(P_SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_LAST = COORD_W'(P_SCREEN_H - 1);

  tri_state_t                 state_reg, state_next;
  logic [1:0]                 vcnt_reg;
  logic signed [COORD_W-1:0]  vx_reg [3];
  logic signed [COORD_W-1:0]  vy_reg [3];
  logic [7:0]                 vz_reg [3];
  logic                       vtx_ready_reg;
  logic                       accept, cull, handshake, area_nonpos;
  logic signed [COORD_W-1:0]  xmin_next, xmax_next, ymin_next, ymax_next;
  logic signed [COORD_W-1:0]  xmin_reg, xmax_reg, ymin_reg, ymax_reg;
  logic [BBOX_W-1:0]          bb_xmin_next, bb_xmax_next, bb_ymin_next, bb_ymax_next;
  logic signed [AREA_W-1:0]   area_w;

  edge_area u_edge_area (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (state_reg == S_SETUP),
    .x0    (vx_reg[0]),
    .y0    (vy_reg[0]),
    .x1    (vx_reg[1]),
    .y1    (vy_reg[1]),
    .x2    (vx_reg[2]),
    .y2    (vy_reg[2]),
    .area  (area_w)
  );

  // Unclamped extents of the three stored vertices.
  always_comb begin
    xmin_next = vx_reg[0];
    xmax_next = vx_reg[0];
    ymin_next = vy_reg[0];
    ymax_next = vy_reg[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_reg[i] < xmin_next) xmin_next = vx_reg[i];
      if (vx_reg[i] > xmax_next) xmax_next = vx_reg[i];
      if (vy_reg[i] < ymin_next) ymin_next = vy_reg[i];
      if (vy_reg[i] > ymax_next) ymax_next = vy_reg[i];
    end
  end

  // A triangle that survives culling overlaps the screen, so only the low
  // side of the minimum and the high side of the maximum need clamping.
  always_comb begin
    area_nonpos  = area_w[AREA_W-1] || (area_w == '0);
    cull         = ((P_CULL_BACK != 0) && area_nonpos) ||
                   xmax_reg[COORD_W-1] || ymax_reg[COORD_W-1] ||
                   (xmin_reg > X_LAST) || (ymin_reg > Y_LAST);
    bb_xmin_next = xmin_reg[COORD_W-1] ? '0 : xmin_reg[BBOX_W-1:0];
    bb_ymin_next = ymin_reg[COORD_W-1] ? '0 : ymin_reg[BBOX_W-1:0];
    bb_xmax_next = (xmax_reg > X_LAST) ? X_LAST[BBOX_W-1:0] : xmax_reg[BBOX_W-1:0];
    bb_ymax_next = (ymax_reg > Y_LAST) ? Y_LAST[BBOX_W-1:0] : ymax_reg[BBOX_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      S_COLLECT: begin
        if (i_vtx_valid && vtx_ready_reg) begin
          accept = 1'b1;
          if (vcnt_reg == 2'd2) state_next = S_SETUP;
        end
      end
      S_SETUP:  state_next = S_CULL;
      S_CULL:   state_next = cull ? S_COLLECT : S_OUTPUT;
      S_OUTPUT: begin
        if (i_tri_ready) begin
          handshake  = 1'b1;
          state_next = S_COLLECT;
        end
      end
      default:  state_next = S_COLLECT;
    endcase
  end

  assign o_vtx_ready = vtx_ready_reg;
  assign o_tri_valid = (state_reg == S_OUTPUT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= S_COLLECT;
      vcnt_reg      <= 2'd0;
      vtx_ready_reg <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx_reg[i] <= '0;
        vy_reg[i] <= '0;
        vz_reg[i] <= '0;
      end
      xmin_reg <= '0;  xmax_reg <= '0;  ymin_reg <= '0;  ymax_reg <= '0;
      o_v0_x <= '0;  o_v0_y <= '0;  o_v1_x <= '0;
      o_v1_y <= '0;  o_v2_x <= '0;  o_v2_y <= '0;
      o_v0_z <= '0;  o_v1_z <= '0;  o_v2_z <= '0;
      o_bb_xmin <= '0;  o_bb_xmax <= '0;  o_bb_ymin <= '0;  o_bb_ymax <= '0;
      o_area       <= '0;
      o_tri_count  <= '0;
      o_cull_count <= '0;
    end else begin
      state_reg <= state_next;
      // Registered ready: low through reset, high on the first edge after it.
      vtx_ready_reg <= (state_next == S_COLLECT);
      if (accept) begin
        vx_reg[vcnt_reg] <= q16_to_pix(i_vtx_x);
        vy_reg[vcnt_reg] <= q16_to_pix(i_vtx_y);
        vz_reg[vcnt_reg] <= i_vtx_z;
        vcnt_reg         <= (vcnt_reg == 2'd2) ? 2'd0 : vcnt_reg + 2'd1;
      end
      if (state_reg == S_SETUP) begin
        xmin_reg <= xmin_next;  xmax_reg <= xmax_next;
        ymin_reg <= ymin_next;  ymax_reg <= ymax_next;
      end
      if (state_reg == S_CULL) begin
        if (cull) begin
          o_cull_count <= o_cull_count + 16'd1;
        end else begin
          o_v0_x <= vx_reg[0];  o_v0_y <= vy_reg[0];  o_v0_z <= vz_reg[0];
          o_v1_x <= vx_reg[1];  o_v1_y <= vy_reg[1];  o_v1_z <= vz_reg[1];
          o_v2_x <= vx_reg[2];  o_v2_y <= vy_reg[2];  o_v2_z <= vz_reg[2];
          o_bb_xmin <= bb_xmin_next;  o_bb_xmax <= bb_xmax_next;
          o_bb_ymin <= bb_ymin_next;  o_bb_ymax <= bb_ymax_next;
          o_area    <= area_w;
        end
      end
      if (handshake) o_tri_count <= o_tri_count + 16'd1;
    end
  end

endmodule
